// File: rtl/aes_pkg.sv
// Shared AES definitions: round/width constants, key-expansion FSM states,
// round constants and the forward S-box lookup.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StFinish
    } keyexp_state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-expansion bus: key handshake, round-key stream and key-store read port.
// The engine is the slave; the key source / consumer side is the master.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_in;
    logic             rk_valid;
    logic [3:0]       rk_idx;
    logic [KEY_W-1:0] rk_data;
    logic             done;
    logic             busy;
    logic [3:0]       rd_idx;
    logic [KEY_W-1:0] rd_key;

    modport master (
        output key_valid, key_in, rd_idx,
        input  key_ready, rk_valid, rk_idx, rk_data, done, busy, rd_key
    );

    modport slave (
        input  key_valid, key_in, rd_idx,
        output key_ready, rk_valid, rk_idx, rk_data, done, busy, rd_key
    );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o[31:24] = aes_sbox(word_i[31:24]);
        word_o[23:16] = aes_sbox(word_i[23:16]);
        word_o[15:8]  = aes_sbox(word_i[15:8]);
        word_o[7:0]   = aes_sbox(word_i[7:0]);
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 forward key expansion, one round key per cycle, streamed and stored.
// Define AES_KEYEXP_STORE_EN to build the 11-entry key store and its read port.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    aes_key_expand_if.slave  kx
);

    keyexp_state_e    state_q, state_d;
    logic [KEY_W-1:0] w_q, w_d;
    logic [3:0]       rk_cnt_q, rk_cnt_d;
    logic             key_ready_q, key_ready_d;
    logic             clr_valid;
    logic             store_we;

    logic [31:0]      rot_w3, sub_w3, temp;
    logic [7:0]       rcon;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;
    logic             last_round;

    assign last_round = (rk_cnt_q == 4'(NR));
    assign rot_w3     = {w_q[23:0], w_q[31:24]};

    aes_sub_word u_sub_word (
        .word_i (rot_w3),
        .word_o (sub_w3)
    );

    // Rcon is only meaningful for rounds 0..9; the round-10 "next key" is discarded.
    always_comb begin
        rcon = 8'h00;
        if (!last_round) begin
            rcon = RCON[rk_cnt_q];
        end
    end

    always_comb begin
        temp = sub_w3 ^ {rcon, 24'h0};
        w0_n = w_q[127:96] ^ temp;
        w1_n = w_q[95:64]  ^ w0_n;
        w2_n = w_q[63:32]  ^ w1_n;
        w3_n = w_q[31:0]   ^ w2_n;
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        rk_cnt_d  = rk_cnt_q;
        clr_valid = 1'b0;
        store_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (kx.key_valid && key_ready_q) begin
                    w_d       = kx.key_in;
                    rk_cnt_d  = 4'd0;
                    clr_valid = 1'b1;
                    state_d   = StExpand;
                end
            end
            StExpand: begin
                store_we = 1'b1;
                w_d      = {w0_n, w1_n, w2_n, w3_n};
                if (last_round) begin
                    state_d = StFinish;
                end else begin
                    rk_cnt_d = rk_cnt_q + 4'd1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        key_ready_d = (state_d == StIdle);
    end

    // key_ready is registered so it stays low for the whole reset assertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            w_q         <= '0;
            rk_cnt_q    <= 4'd0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            rk_cnt_q    <= rk_cnt_d;
            key_ready_q <= key_ready_d;
        end
    end

    always_comb begin
        kx.key_ready = key_ready_q;
        kx.rk_valid  = (state_q == StExpand);
        kx.rk_idx    = kx.rk_valid ? rk_cnt_q : 4'd0;
        kx.rk_data   = kx.rk_valid ? w_q : '0;
        kx.done      = kx.rk_valid && last_round;
        kx.busy      = (state_q != StIdle);
    end

`ifdef AES_KEYEXP_STORE_EN
    logic [KEY_W-1:0] store_q [NR+1];
    logic [NR:0]      vld_q;
    logic [KEY_W-1:0] rd_key_q;

    // Registered read sees pre-write contents, so a same-cycle write is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q  <= '{default: '0};
            vld_q    <= '0;
            rd_key_q <= '0;
        end else begin
            if ((kx.rd_idx <= 4'(NR)) && vld_q[kx.rd_idx]) begin
                rd_key_q <= store_q[kx.rd_idx];
            end else begin
                rd_key_q <= '0;
            end
            if (clr_valid) begin
                vld_q <= '0;
            end
            if (store_we) begin
                store_q[rk_cnt_q] <= w_q;
                vld_q[rk_cnt_q]   <= 1'b1;
            end
        end
    end

    assign kx.rd_key = rd_key_q;
`else
    logic unused_store;
    assign unused_store = ^{kx.rd_idx, clr_valid, store_we};
    assign kx.rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors through a scoreboard queue,
// handshake timing, key-store reads and mid-expansion reset.
module tb_aes_key_expand;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        int           idx;
        logic [127:0] data;
        bit           known;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   c0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_expand_if kx ();

    aes_key_expand dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_rd(input logic [127:0] v);
`ifdef AES_KEYEXP_STORE_EN
        return v;
`else
        return 128'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sched(input logic [127:0] k0, input logic [127:0] rk1,
                              input logic [127:0] rk10, input int base);
        for (int k = 0; k <= 10; k++) begin
            exp_t e;
            e.idx   = k;
            e.cyc   = base + k;
            e.known = (k <= 1) || (k == 10);
            e.data  = (k == 0) ? k0 : ((k == 1) ? rk1 : rk10);
            sb.push_back(e);
        end
    endtask

    // Leaves the bench in cycle T+1 (first EXPAND cycle) with base = cycle stamp of rk 0.
    task automatic accept(input logic [127:0] key, output int base);
        kx.key_in    = key;
        kx.key_valid = 1'b1;
        check("ready_before_accept", 128'(kx.key_ready), 128'd1);
        step();
        kx.key_valid = 1'b0;
        base = cyc;
        check("busy_after_accept", 128'(kx.busy), 128'd1);
        check("ready_after_accept", 128'(kx.key_ready), 128'd0);
    endtask

    task automatic read(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        kx.rd_idx = idx;
        step();
        check(tag, kx.rd_key, exp);
    endtask

    // Stream monitor: each presented round key pops one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (kx.rk_valid) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_underflow: observed rk_idx %0d, expected no round key",
                           kx.rk_idx);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rk_idx", 128'(kx.rk_idx), 128'(mon_e.idx));
                    check("rk_cycle", 128'(cyc), 128'(mon_e.cyc));
                    check("rk_done", 128'(kx.done), 128'(mon_e.idx == 10));
                    check("rk_busy", 128'(kx.busy), 128'd1);
                    if (mon_e.known) begin
                        check("rk_data", kx.rk_data, mon_e.data);
                    end
                end
            end else begin
                check("done_without_rk", 128'(kx.done), 128'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100us");
        $fatal(1, "timeout");
    end

    initial begin
        kx.key_valid = 1'b0;
        kx.key_in    = '0;
        kx.rd_idx    = 4'd0;

        // Reset state
        #2;
        check("rst_key_ready", 128'(kx.key_ready), 128'd0);
        check("rst_rk_valid", 128'(kx.rk_valid), 128'd0);
        check("rst_rk_idx", 128'(kx.rk_idx), 128'd0);
        check("rst_rk_data", kx.rk_data, 128'd0);
        check("rst_done", 128'(kx.done), 128'd0);
        check("rst_busy", 128'(kx.busy), 128'd0);
        check("rst_rd_key", kx.rd_key, 128'd0);
        step();
        rst = 1'b0;
        step();
        check("ready_after_release", 128'(kx.key_ready), 128'd1);
        check("busy_after_release", 128'(kx.busy), 128'd0);

        // FIPS-197 A.1 key
        accept(KEY_A1, c0);
        push_sched(KEY_A1, A1_RK1, A1_RK10, c0);
        step();
        step();
        kx.rd_idx = 4'd5;
        step();
        check("rd_unwritten_idx5", kx.rd_key, 128'd0);
        repeat (7) step();
        check("a1_done_t11", 128'(kx.done), 128'd1);
        check("a1_idx_t11", 128'(kx.rk_idx), 128'd10);
        check("a1_rk10_t11", kx.rk_data, A1_RK10);
        step();
        check("finish_ready", 128'(kx.key_ready), 128'd0);
        check("finish_busy", 128'(kx.busy), 128'd1);
        check("finish_rk_valid", 128'(kx.rk_valid), 128'd0);
        step();
        check("t13_ready", 128'(kx.key_ready), 128'd1);
        check("t13_busy", 128'(kx.busy), 128'd0);
        read(4'd10, exp_rd(A1_RK10), "rd_a1_idx10");
        read(4'd11, 128'd0, "rd_idx11");
        read(4'd15, 128'd0, "rd_idx15");
        read(4'd0, exp_rd(KEY_A1), "rd_a1_idx0");
        read(4'd1, exp_rd(A1_RK1), "rd_a1_idx1");

        // All-zero key; store valid bits must be cleared on accept
        accept(128'd0, c0);
        push_sched(128'd0, Z_RK1, Z_RK10, c0);
        step();
        kx.rd_idx = 4'd10;
        step();
        check("rd_cleared_idx10", kx.rd_key, 128'd0);
        kx.rd_idx = 4'd2;
        step();
        check("rd_before_write_idx2", kx.rd_key, 128'd0);
        repeat (9) step();
        check("zero_t13_ready", 128'(kx.key_ready), 128'd1);

        // key_valid held high: second key only at T+13
        kx.key_in    = KEY_A1;
        kx.key_valid = 1'b1;
        step();
        c0 = cyc;
        push_sched(KEY_A1, A1_RK1, A1_RK10, c0);
        push_sched(128'd0, Z_RK1, Z_RK10, c0 + 13);
        kx.key_in = '0;
        repeat (11) step();
        check("held_t12_ready", 128'(kx.key_ready), 128'd0);
        step();
        check("held_t13_ready", 128'(kx.key_ready), 128'd1);
        step();
        kx.key_valid = 1'b0;
        check("held_second_busy", 128'(kx.busy), 128'd1);
        repeat (10) step();
        check("held_second_done", 128'(kx.done), 128'd1);
        step();
        step();
        check("held_end_ready", 128'(kx.key_ready), 128'd1);
        read(4'd0, 128'd0, "rd_held_idx0");
        read(4'd1, exp_rd(Z_RK1), "rd_held_idx1");
        read(4'd10, exp_rd(Z_RK10), "rd_held_idx10");

        // Reset in cycle T+5 aborts the expansion
        accept(KEY_A1, c0);
        push_sched(KEY_A1, A1_RK1, A1_RK10, c0);
        kx.rd_idx = 4'd0;
        repeat (4) step();
        check("rd_before_reset", kx.rd_key, exp_rd(KEY_A1));
        check("idx_before_reset", 128'(kx.rk_idx), 128'd4);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rk_valid", 128'(kx.rk_valid), 128'd0);
        check("abort_rk_idx", 128'(kx.rk_idx), 128'd0);
        check("abort_rk_data", kx.rk_data, 128'd0);
        check("abort_done", 128'(kx.done), 128'd0);
        check("abort_busy", 128'(kx.busy), 128'd0);
        check("abort_key_ready", 128'(kx.key_ready), 128'd0);
        check("abort_rd_key", kx.rd_key, 128'd0);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        step();
        check("abort_release_ready", 128'(kx.key_ready), 128'd1);
        check("abort_release_busy", 128'(kx.busy), 128'd0);
        check("abort_store_idx0", kx.rd_key, 128'd0);
        read(4'd3, 128'd0, "abort_store_idx3");
        repeat (15) step();

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
